// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the arbiter that fronts it.
package alu_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. The pointer register belongs to the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid
);

  // Scan ptr, ptr+1, ... and stop at the first requester found.
  always_comb begin
    int pos;
    logic [ID_W-1:0] idx;
    gnt       = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    pos       = 0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = pos[ID_W-1:0];
      if (en && !gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between NUM_REQ requesters. One operation is in
// flight at a time: IDLE accepts, EXEC lets the ALU evaluate the latched
// operands for one cycle, RESP holds the result until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A requester holds its req_* stable while req_valid is high and
// req_ready is low; the response side holds rsp_* stable while rsp_valid is
// high and rsp_ready is low. ready is never a function of a later cycle.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = alu_pkg::XLEN,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_a,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_b,
  input  logic [NUM_REQ-1:0][2:0]        req_op,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [XLEN-1:0]                rsp_result,
  output logic                           rsp_zero,
  output logic [XLEN-1:0]                alu_a,
  output logic [XLEN-1:0]                alu_b,
  output logic [2:0]                     alu_control,
  input  logic [XLEN-1:0]                alu_result,
  input  logic                           alu_zero,
  output alu_pkg::arb_state_t            state,
  output logic [ID_W-1:0]                ptr
);

  import alu_pkg::*;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_valid;
  logic               arb_en;

  // Only arbitrate while idle and out of reset, so req_ready is zero otherwise.
  assign arb_en = rst_n && (state == IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (arb_en),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  assign req_ready = gnt;

  // Operation FSM; operand and response registers drive the outputs directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            alu_a       <= req_a[gnt_id];
            alu_b       <= req_b[gnt_id];
            alu_control <= req_op[gnt_id];
            rsp_id      <= gnt_id;
            ptr         <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural stand-in for the ALU.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int EW      = ID_W + 1 + XLEN;

  logic                         clk;
  logic                         rst_n;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0][XLEN-1:0] req_a;
  logic [NUM_REQ-1:0][XLEN-1:0] req_b;
  logic [NUM_REQ-1:0][2:0]      req_op;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ID_W-1:0]              rsp_id;
  logic [XLEN-1:0]              rsp_result;
  logic                         rsp_zero;
  logic [XLEN-1:0]              alu_a;
  logic [XLEN-1:0]              alu_b;
  logic [2:0]                   alu_control;
  logic [XLEN-1:0]              alu_result;
  logic                         alu_zero;
  arb_state_t                   state;
  logic [ID_W-1:0]              ptr;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0]   exp_q[$];
  logic [ID_W-1:0] gnt_q[$];

  alu_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .state(state), .ptr(ptr)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Stand-in for the external ALU: unknown codes return 0.
  always_comb begin
    case (alu_control)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: responses, popped on each handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp id=%0d result=%0h", rsp_id, rsp_result);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("rsp_id",     XLEN'(rsp_id),   XLEN'(e[EW-1 -: ID_W]));
        check("rsp_zero",   XLEN'(rsp_zero), XLEN'(e[XLEN]));
        check("rsp_result", rsp_result,      e[XLEN-1:0]);
      end
    end
  end

  // Grant monitor: every nonzero req_ready must match the expected grant.
  always @(negedge clk) begin
    if (rst_n && req_ready != '0) begin
      if (gnt_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant req_ready=%b", req_ready);
      end else begin
        logic [ID_W-1:0]    g;
        logic [NUM_REQ-1:0] v;
        g    = gnt_q.pop_front();
        v    = '0;
        v[g] = 1'b1;
        check("grant", XLEN'(req_ready), XLEN'(v));
      end
    end
  end

  // Driver tasks
  task automatic push_rsp(input logic [ID_W-1:0] id, input logic z, input logic [XLEN-1:0] r);
    exp_q.push_back({id, z, r});
  endtask

  task automatic issue(input logic [ID_W-1:0] r, input logic [2:0] op,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_a[r]     = a;
    req_b[r]     = b;
    req_op[r]    = op;
    req_valid[r] = 1'b1;
  endtask

  task automatic wait_accept(input logic [ID_W-1:0] r);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready[r]) done = 1'b1;
    end
    if (done) begin
      @(posedge clk);
      #1 req_valid[r] = 1'b0;
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout requester=%0d", r);
      req_valid[r] = 1'b0;
    end
  endtask

  task automatic wait_grants(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      @(negedge clk);
      if (req_ready != '0) seen++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL grants_timeout actual=%0d expected=%0d", seen, n);
    end
    @(posedge clk);
    #1 req_valid = '0;
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && state == IDLE) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus
  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;

    // 1. reset and idle
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready",   XLEN'(req_ready),   '0);
    check("rst_rsp_valid",   XLEN'(rsp_valid),   '0);
    check("rst_rsp_id",      XLEN'(rsp_id),      '0);
    check("rst_rsp_result",  rsp_result,         '0);
    check("rst_rsp_zero",    XLEN'(rsp_zero),    '0);
    check("rst_alu_a",       alu_a,              '0);
    check("rst_alu_b",       alu_b,              '0);
    check("rst_alu_control", XLEN'(alu_control), '0);
    check("rst_ptr",         XLEN'(ptr),         '0);
    @(negedge clk);
    check("idle_state",      XLEN'(state),       XLEN'(IDLE));

    // 2. single request, ADD 5+7, two-edge latency
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    gnt_q.push_back(1'b0);
    push_rsp(1'b0, 1'b0, 64'd12);
    issue(1'b0, ALU_ADD, 64'd5, 64'd7);
    wait_accept(1'b0);
    @(negedge clk);
    check("exec_rsp_valid", XLEN'(rsp_valid),   '0);
    check("exec_alu_a",     alu_a,              64'd5);
    check("exec_alu_b",     alu_b,              64'd7);
    check("exec_alu_ctl",   XLEN'(alu_control), XLEN'(ALU_ADD));
    @(negedge clk);
    check("lat_rsp_valid",  XLEN'(rsp_valid),   64'd1);
    wait_drain();
    check("ptr_after_r0",   XLEN'(ptr),         64'd1);

    // requester 1 alone brings the pointer back to 0
    gnt_q.push_back(1'b1);
    push_rsp(1'b1, 1'b0, 64'h0F00);
    issue(1'b1, ALU_AND, 64'hFF00, 64'h0FF0);
    wait_accept(1'b1);
    wait_drain();
    check("ptr_after_r1",   XLEN'(ptr),         64'd0);

    // 3. contention: grants alternate 0,1,0,1
    for (int k = 0; k < 2; k++) begin
      gnt_q.push_back(1'b0);
      gnt_q.push_back(1'b1);
      push_rsp(1'b0, 1'b1, 64'd0);
      push_rsp(1'b1, 1'b0, 64'hFF);
    end
    issue(1'b0, ALU_SUB, 64'd9, 64'd9);
    issue(1'b1, ALU_OR, 64'hF0, 64'h0F);
    wait_grants(4);
    wait_drain();

    // 4. backpressure with requester 1 waiting
    rsp_ready = 1'b0;
    gnt_q.push_back(1'b0);
    gnt_q.push_back(1'b1);
    push_rsp(1'b0, 1'b0, 64'd123);
    push_rsp(1'b1, 1'b0, 64'd7);
    issue(1'b0, ALU_ADD, 64'd100, 64'd23);
    wait_accept(1'b0);
    issue(1'b1, ALU_SUB, 64'd10, 64'd3);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1'b1;
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL bp_rsp_timeout rsp_valid=%b", rsp_valid);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", XLEN'(rsp_valid), 64'd1);
      check("bp_rsp_result", rsp_result,      64'd123);
      check("bp_rsp_id",    XLEN'(rsp_id),    64'd0);
      check("bp_req_ready", XLEN'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_grant_after_hs", XLEN'(req_ready), 64'b10);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_drain();

    // 5. wrap-around and an unassigned op code
    gnt_q.push_back(1'b0);
    push_rsp(1'b0, 1'b1, 64'd0);
    issue(1'b0, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    wait_accept(1'b0);
    wait_drain();
    gnt_q.push_back(1'b1);
    push_rsp(1'b1, 1'b1, 64'd0);
    issue(1'b1, 3'b111, 64'h1234, 64'h5678);
    wait_accept(1'b1);
    @(negedge clk);
    check("illegal_op_passthru", XLEN'(alu_control), 64'd7);
    wait_drain();

    // 6. reset during EXEC discards the operation
    gnt_q.push_back(1'b0);
    issue(1'b0, ALU_OR, 64'd3, 64'd4);
    wait_accept(1'b0);
    check("pre_rst_state", XLEN'(state), XLEN'(EXEC));
    check("pre_rst_ptr",   XLEN'(ptr),   64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_rsp_valid", XLEN'(rsp_valid), 64'd0);
    check("mid_rst_ptr",       XLEN'(ptr),       64'd0);
    check("mid_rst_state",     XLEN'(state),     XLEN'(IDLE));
    check("mid_rst_req_ready", XLEN'(req_ready), 64'd0);
    check("mid_rst_alu_a",     alu_a,            64'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_rsp_valid", XLEN'(rsp_valid), 64'd0);

    // Final report
    check("rsp_queue_empty", XLEN'(exp_q.size()), 64'd0);
    check("gnt_queue_empty", XLEN'(gnt_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
